// File: rtl/commit_trace_drain.sv
// commit_trace_drain: receiving end of the commit record stream.
// Compacts up to CW retired-instruction records per cycle, in lane order, into
// an on-chip FIFO and drains them one per cycle to a trace sink over
// valid/ready. Each record carries a 16-bit sequence number so the sink can
// detect drops. Groups that do not fit are dropped whole and counted.
//
// Optional feature macro: NCPU_TRACE_TIMESTAMP_EN adds a free-running 32-bit
// cycle counter and the trc_ts output (push-cycle timestamp per record).
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   cmt_valid/pc/ins/we/waddr/wdat per-lane commit record (CW lanes, packed)
//   cmt_excp, cmt_excp_vect       exception flush, attached to first record
//   trc_valid, trc_ready          head record handshake
//   trc_pc .. trc_excp_vect       head record fields (combinational from FIFO)
//   trc_seq                       head record sequence number
//   trc_ts                        head record timestamp (macro only)
//   trc_level                     FIFO occupancy
//   trc_ovf, trc_drop_cnt         sticky overflow flag, saturating drop count
module commit_trace_drain #(
  parameter int unsigned CONFIG_DW             = 32,
  parameter int unsigned CONFIG_P_COMMIT_WIDTH = 1,
  parameter int unsigned CONFIG_P_FIFO_DEPTH   = 4,
  parameter int unsigned PC_W                  = 32,
  parameter int unsigned NCPU_INSN_DW          = 32,
  parameter int unsigned NCPU_LRF_AW           = 5
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]              cmt_valid,
  input  logic [PC_W*(1<<CONFIG_P_COMMIT_WIDTH)-1:0]         cmt_pc,
  input  logic [NCPU_INSN_DW*(1<<CONFIG_P_COMMIT_WIDTH)-1:0] cmt_ins,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]              cmt_we,
  input  logic [NCPU_LRF_AW*(1<<CONFIG_P_COMMIT_WIDTH)-1:0]  cmt_waddr,
  input  logic [CONFIG_DW*(1<<CONFIG_P_COMMIT_WIDTH)-1:0]    cmt_wdat,
  input  logic                                          cmt_excp,
  input  logic [7:0]                                    cmt_excp_vect,
  output logic                                          trc_valid,
  input  logic                                          trc_ready,
  output logic [PC_W-1:0]                               trc_pc,
  output logic [NCPU_INSN_DW-1:0]                       trc_ins,
  output logic                                          trc_we,
  output logic [NCPU_LRF_AW-1:0]                        trc_waddr,
  output logic [CONFIG_DW-1:0]                          trc_wdat,
  output logic                                          trc_excp,
  output logic [7:0]                                    trc_excp_vect,
  output logic [15:0]                                   trc_seq,
`ifdef NCPU_TRACE_TIMESTAMP_EN
  output logic [31:0]                                   trc_ts,
`endif
  output logic [CONFIG_P_FIFO_DEPTH:0]                  trc_level,
  output logic                                          trc_ovf,
  output logic [15:0]                                   trc_drop_cnt
);

  localparam int unsigned CW    = 1 << CONFIG_P_COMMIT_WIDTH;
  localparam int unsigned DEPTH = 1 << CONFIG_P_FIFO_DEPTH;
  localparam int unsigned AW    = CONFIG_P_FIFO_DEPTH;
  localparam int unsigned PW    = CONFIG_P_FIFO_DEPTH + 1;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wptr_q, rptr_q;
  logic [15:0]   seq_q;
  logic          ovf_q;
  logic [15:0]   drop_q;

  logic [PW-1:0] level, free_slots, n_rec, run;
  logic [PW-1:0] lane_off [CW];
  logic [CW-1:0] lane_wr, lane_first;
  logic          excp_only, admit, pop;
  logic [16:0]   drop_sum;
  logic [AW-1:0] head;

  // FIFO payload storage (not reset).
  logic [PC_W-1:0]         mem_pc    [DEPTH];
  logic [NCPU_INSN_DW-1:0] mem_ins   [DEPTH];
  logic                    mem_we    [DEPTH];
  logic [NCPU_LRF_AW-1:0]  mem_waddr [DEPTH];
  logic [CONFIG_DW-1:0]    mem_wdat  [DEPTH];
  logic                    mem_excp  [DEPTH];
  logic [7:0]              mem_vect  [DEPTH];
  logic [15:0]             mem_seq   [DEPTH];

`ifdef NCPU_TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] mem_ts [DEPTH];
`endif

  // Group sizing, lane-order compaction offsets and admission decision.
  always_comb begin
    run        = '0;
    lane_wr    = '0;
    lane_first = '0;
    for (int l = 0; l < CW; l++) begin
      lane_off[l] = run;
      if (cmt_valid[l]) begin
        lane_wr[l] = 1'b1;
        run        = run + PW'(1);
      end
    end
    // An exception with no retiring lane still produces one record from lane 0.
    excp_only = cmt_excp & ~(|cmt_valid);
    if (excp_only) begin
      lane_wr[0] = 1'b1;
      n_rec      = PW'(1);
    end else begin
      n_rec      = run;
    end
    for (int l = 0; l < CW; l++) begin
      lane_first[l] = lane_wr[l] && (lane_off[l] == '0);
    end
    level      = wptr_q - rptr_q;
    free_slots = PW'(DEPTH) - level;
    // Space is judged before this cycle's pop.
    admit      = (n_rec <= free_slots);
    pop        = trc_valid & trc_ready;
    drop_sum   = {1'b0, drop_q} + 17'(n_rec);
  end

  // Pointer, sequence and drop bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      seq_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      seq_q <= seq_q + 16'(n_rec);
      if (admit) begin
        wptr_q <= wptr_q + n_rec;
      end else begin
        ovf_q  <= 1'b1;
        drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
    end
  end

`ifdef NCPU_TRACE_TIMESTAMP_EN
  // Free-running cycle counter used to stamp pushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_q + 32'd1;
  end
`endif

  // Payload write: each admitted lane lands at wptr + its compacted offset.
  always_ff @(posedge clk) begin
    if (admit) begin
      for (int l = 0; l < CW; l++) begin
        if (lane_wr[l]) begin
          mem_pc   [AW'(wptr_q + lane_off[l])] <= cmt_pc[l*PC_W +: PC_W];
          mem_ins  [AW'(wptr_q + lane_off[l])] <= cmt_ins[l*NCPU_INSN_DW +: NCPU_INSN_DW];
          mem_we   [AW'(wptr_q + lane_off[l])] <= cmt_we[l] & cmt_valid[l];
          mem_waddr[AW'(wptr_q + lane_off[l])] <= cmt_waddr[l*NCPU_LRF_AW +: NCPU_LRF_AW];
          mem_wdat [AW'(wptr_q + lane_off[l])] <= cmt_wdat[l*CONFIG_DW +: CONFIG_DW];
          mem_excp [AW'(wptr_q + lane_off[l])] <= cmt_excp & lane_first[l];
          mem_vect [AW'(wptr_q + lane_off[l])] <= (cmt_excp & lane_first[l]) ? cmt_excp_vect : 8'h00;
          mem_seq  [AW'(wptr_q + lane_off[l])] <= seq_q + 16'(lane_off[l]);
`ifdef NCPU_TRACE_TIMESTAMP_EN
          mem_ts   [AW'(wptr_q + lane_off[l])] <= ts_q;
`endif
        end
      end
    end
  end

  // Head record presentation.
  assign head          = rptr_q[AW-1:0];
  assign trc_valid     = (level != '0);
  assign trc_pc        = mem_pc[head];
  assign trc_ins       = mem_ins[head];
  assign trc_we        = mem_we[head];
  assign trc_waddr     = mem_waddr[head];
  assign trc_wdat      = mem_wdat[head];
  assign trc_excp      = mem_excp[head];
  assign trc_excp_vect = mem_vect[head];
  assign trc_seq       = mem_seq[head];
`ifdef NCPU_TRACE_TIMESTAMP_EN
  assign trc_ts        = mem_ts[head];
`endif
  assign trc_level     = level;
  assign trc_ovf       = ovf_q;
  assign trc_drop_cnt  = drop_q;

endmodule

// File: tb/tb_commit_trace_drain.sv
// Directed bench for commit_trace_drain (CW=2, DEPTH=16).
module tb_commit_trace_drain;

  logic        clk;
  logic        rst;
  logic [1:0]  cmt_valid;
  logic [63:0] cmt_pc;
  logic [63:0] cmt_ins;
  logic [1:0]  cmt_we;
  logic [9:0]  cmt_waddr;
  logic [63:0] cmt_wdat;
  logic        cmt_excp;
  logic [7:0]  cmt_excp_vect;
  logic        trc_valid;
  logic        trc_ready;
  logic [31:0] trc_pc;
  logic [31:0] trc_ins;
  logic        trc_we;
  logic [4:0]  trc_waddr;
  logic [31:0] trc_wdat;
  logic        trc_excp;
  logic [7:0]  trc_excp_vect;
  logic [15:0] trc_seq;
`ifdef NCPU_TRACE_TIMESTAMP_EN
  logic [31:0] trc_ts;
`endif
  logic [4:0]  trc_level;
  logic        trc_ovf;
  logic [15:0] trc_drop_cnt;

  int checks = 0;
  int errors = 0;

  commit_trace_drain dut (
    .clk(clk), .rst(rst),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_ins(cmt_ins), .cmt_we(cmt_we),
    .cmt_waddr(cmt_waddr), .cmt_wdat(cmt_wdat), .cmt_excp(cmt_excp),
    .cmt_excp_vect(cmt_excp_vect),
    .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_pc(trc_pc), .trc_ins(trc_ins), .trc_we(trc_we), .trc_waddr(trc_waddr),
    .trc_wdat(trc_wdat), .trc_excp(trc_excp), .trc_excp_vect(trc_excp_vect),
    .trc_seq(trc_seq),
`ifdef NCPU_TRACE_TIMESTAMP_EN
    .trc_ts(trc_ts),
`endif
    .trc_level(trc_level), .trc_ovf(trc_ovf), .trc_drop_cnt(trc_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cmt_valid     = 2'b00;
    cmt_pc        = '0;
    cmt_ins       = '0;
    cmt_we        = 2'b00;
    cmt_waddr     = '0;
    cmt_wdat      = '0;
    cmt_excp      = 1'b0;
    cmt_excp_vect = 8'h00;
  endtask

  task automatic push(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    idle();
    cmt_valid = v;
    cmt_pc    = {pc1, pc0};
    cmt_ins   = 64'h0000_0013_0000_0013;
    cmt_we    = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    trc_ready = 1'b1;
    idle();
    repeat (3) step();
    chk("rst_valid", 64'(trc_valid), 64'd0);
    chk("rst_level", 64'(trc_level), 64'd0);
    chk("rst_ovf",   64'(trc_ovf),   64'd0);
    chk("rst_drop",  64'(trc_drop_cnt), 64'd0);
    rst = 1'b1;

    // Two-lane group drains in lane order on consecutive cycles.
    push(2'b11, 32'h100, 32'h104);
    step();
    idle();
    chk("t1_valid", 64'(trc_valid), 64'd1);
    chk("t1_pc0",   64'(trc_pc),    64'h100);
    chk("t1_seq0",  64'(trc_seq),   64'd0);
    chk("t1_lvl",   64'(trc_level), 64'd2);
    chk("t1_excp0", 64'(trc_excp),  64'd0);
    step();
    chk("t1_pc1",   64'(trc_pc),    64'h104);
    chk("t1_seq1",  64'(trc_seq),   64'd1);
    step();
    chk("t1_empty", 64'(trc_valid), 64'd0);

    // Only lane 1 valid, with exception attached.
    do_reset();
    push(2'b10, 32'h999, 32'h200);
    cmt_waddr     = {5'd3, 5'd7};
    cmt_wdat      = {32'hDEAD_BEEF, 32'h1111_1111};
    cmt_excp      = 1'b1;
    cmt_excp_vect = 8'h0C;
    step();
    idle();
    chk("t2_pc",    64'(trc_pc),        64'h200);
    chk("t2_excp",  64'(trc_excp),      64'd1);
    chk("t2_vect",  64'(trc_excp_vect), 64'h0C);
    chk("t2_seq",   64'(trc_seq),       64'd0);
    chk("t2_waddr", 64'(trc_waddr),     64'd3);
    chk("t2_wdat",  64'(trc_wdat),      64'hDEAD_BEEF);
    chk("t2_lvl",   64'(trc_level),     64'd1);
    step();
    chk("t2_empty", 64'(trc_valid), 64'd0);

    // Exception with no valid lane: lane-0 record with we forced low.
    push(2'b00, 32'h300, 32'h304);
    cmt_we        = 2'b11;
    cmt_excp      = 1'b1;
    cmt_excp_vect = 8'h05;
    step();
    idle();
    chk("t2b_pc",   64'(trc_pc),        64'h300);
    chk("t2b_we",   64'(trc_we),        64'd0);
    chk("t2b_excp", 64'(trc_excp),      64'd1);
    chk("t2b_vect", 64'(trc_excp_vect), 64'h05);
    chk("t2b_seq",  64'(trc_seq),       64'd1);
    step();

    // Fill to full, overflow one group, then drain.
    do_reset();
    trc_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push(2'b11, 32'h1000 + 32'(8*i), 32'h1004 + 32'(8*i));
      step();
    end
    chk("t3_full_lvl", 64'(trc_level), 64'd16);
    chk("t3_full_ovf", 64'(trc_ovf),   64'd0);
    push(2'b11, 32'h5000, 32'h5004);
    step();
    idle();
    chk("t3_ovf_lvl",  64'(trc_level),    64'd16);
    chk("t3_ovf",      64'(trc_ovf),      64'd1);
    chk("t3_drop",     64'(trc_drop_cnt), 64'd2);
    chk("t3_valid",    64'(trc_valid),    64'd1);
    trc_ready = 1'b1;
    for (int r = 0; r < 16; r++) begin
      chk("t3_drain_seq", 64'(trc_seq), 64'(r));
      chk("t3_drain_pc",  64'(trc_pc),  64'(32'h1000 + 32'(4*r)));
      step();
    end
    chk("t3_drained", 64'(trc_valid), 64'd0);
    push(2'b01, 32'h2000, 32'h0);
    step();
    idle();
    chk("t3_next_seq", 64'(trc_seq), 64'd18);
    chk("t3_next_pc",  64'(trc_pc),  64'h2000);
    step();
    chk("t3_next_lvl", 64'(trc_level), 64'd0);

    // Level 15: pop does not make room for the same cycle's push.
    trc_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push(2'b11, 32'h40, 32'h44);
      step();
    end
    push(2'b01, 32'h48, 32'h0);
    step();
    chk("t4_lvl15", 64'(trc_level), 64'd15);
    trc_ready = 1'b1;
    push(2'b01, 32'h4C, 32'h0);
    step();
    chk("t4_one_lvl",  64'(trc_level),    64'd15);
    chk("t4_one_drop", 64'(trc_drop_cnt), 64'd2);
    push(2'b11, 32'h50, 32'h54);
    step();
    idle();
    chk("t4_two_lvl",  64'(trc_level),    64'd14);
    chk("t4_two_drop", 64'(trc_drop_cnt), 64'd4);

    // Asynchronous reset with records still buffered.
    repeat (9) step();
    chk("t5_lvl5", 64'(trc_level), 64'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(trc_valid),    64'd0);
    chk("t5_rst_lvl",   64'(trc_level),    64'd0);
    chk("t5_rst_ovf",   64'(trc_ovf),      64'd0);
    chk("t5_rst_drop",  64'(trc_drop_cnt), 64'd0);
    #1;
    rst = 1'b1;
    step();
    chk("t5_post_valid", 64'(trc_valid), 64'd0);
    push(2'b01, 32'h3000, 32'h0);
    step();
    idle();
    chk("t5_post_seq", 64'(trc_seq), 64'd0);
    chk("t5_post_pc",  64'(trc_pc),  64'h3000);
    step();
    chk("t5_post_empty", 64'(trc_valid), 64'd0);

`ifdef NCPU_TRACE_TIMESTAMP_EN
    // Both records of a group pushed at cycle 10 carry timestamp 10.
    do_reset();
    repeat (10) step();
    push(2'b11, 32'h600, 32'h604);
    step();
    idle();
    chk("ts_lane0", 64'(trc_ts), 64'd10);
    step();
    chk("ts_lane1", 64'(trc_ts), 64'd10);
    chk("ts_pc1",   64'(trc_pc), 64'h604);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
